// File: rtl/cpu_pkg.sv
// Shared decode constants for the single-cycle decode stage: opcodes, functs,
// ALU operation encodings, register-address width and the control bundle type.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
        logic branch;
    } ctrl_t;

    function automatic logic [31:0] sign_extend16(input logic [15:0] value);
        return {{16{value[15]}}, value};
    endfunction

endpackage

// File: rtl/register_file.sv
// Two async read ports, one sync write port, R0 hardwired to zero, sync reset.
// Optional macro WB_BYPASS_EN forwards a same-cycle write-back onto the reads.
module register_file
    import cpu_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_COUNT = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] read_addr1,
    input  logic [REG_ADDR_W-1:0] read_addr2,
    output logic [DATA_W-1:0]     read_data1,
    output logic [DATA_W-1:0]     read_data2,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data
);

    logic [DATA_W-1:0] regs [REG_COUNT];

    // Reset wins over a coincident write-back, so the write is simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && (wb_addr != '0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [REG_ADDR_W-1:0] addr);
        logic [DATA_W-1:0] value;
        if (addr == '0) begin
            value = '0;
        end else begin
            value = regs[addr];
`ifdef WB_BYPASS_EN
            if (wb_en && (wb_addr == addr)) begin
                value = wb_data;
            end
`endif
        end
        return value;
    endfunction

    assign read_data1 = read_port(read_addr1);
    assign read_data2 = read_port(read_addr2);

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: field split, control generation, sticky illegal flag and the
// register file. Build with WB_BYPASS_EN to forward write-back data to reads.
module instruction_decode
    import cpu_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_COUNT = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           instruction,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    output logic [DATA_W-1:0]     read_data1,
    output logic [DATA_W-1:0]     read_data2,
    output logic [31:0]           imm_ext,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic                  reg_write,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  mem_to_reg,
    output logic                  alu_src,
    output logic                  branch,
    output logic [3:0]            alu_ctrl,
    output logic                  illegal_instr
);

    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic                  unused_shamt;
    ctrl_t                 ctrl;
    logic                  illegal_now;

    assign opcode       = instruction[31:26];
    assign rs           = instruction[25:21];
    assign rt           = instruction[20:16];
    assign rd           = instruction[15:11];
    assign funct        = instruction[5:0];
    assign unused_shamt = ^instruction[10:6];
    assign imm_ext      = sign_extend16(instruction[15:0]);

    always_comb begin
        ctrl        = '0;
        alu_ctrl    = ALU_AND;
        write_reg   = '0;
        illegal_now = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                write_reg      = rd;
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: begin
                        illegal_now = 1'b1;
                        ctrl        = '0;
                        write_reg   = '0;
                    end
                endcase
            end
            OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
                write_reg       = rt;
                alu_ctrl        = ALU_ADD;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                alu_ctrl       = ALU_ADD;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                alu_ctrl    = ALU_SUB;
            end
            OP_ADDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                write_reg      = rt;
                alu_ctrl       = ALU_ADD;
            end
            default: illegal_now = 1'b1;
        endcase
    end

    assign reg_write  = ctrl.reg_write;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alu_src    = ctrl.alu_src;
    assign branch     = ctrl.branch;

    // Sticky until reset so a later legal instruction cannot hide the fault.
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_instr <= 1'b0;
        end else if (illegal_now) begin
            illegal_instr <= 1'b1;
        end
    end

    register_file #(
        .DATA_W    (DATA_W),
        .REG_COUNT (REG_COUNT)
    ) u_register_file (
        .clk        (clk),
        .reset      (reset),
        .read_addr1 (rs),
        .read_addr2 (rt),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data)
    );

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: directed sequences, a decode
// vector table and a randomized run against a behavioural reference model.
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] imm_ext;
    logic [4:0]  write_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic        branch;
    logic [3:0]  alu_ctrl;
    logic        illegal_instr;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    instruction_decode dut (
        .clk           (clk),
        .reset         (reset),
        .instruction   (instruction),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .read_data1    (read_data1),
        .read_data2    (read_data2),
        .imm_ext       (imm_ext),
        .write_reg     (write_reg),
        .reg_write     (reg_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .alu_src       (alu_src),
        .branch        (branch),
        .alu_ctrl      (alu_ctrl),
        .illegal_instr (illegal_instr)
    );

`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // Reference state
    logic [31:0] model_regs [32];
    logic        model_ill;

    // Control bits ordered {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch}
    typedef struct {
        logic [31:0] instr;
        logic [5:0]  ctrl;
        logic [3:0]  alu;
        logic [4:0]  wreg;
        logic [31:0] imm;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [5:0] got_ctrl();
        return {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch};
    endfunction

    // Specification-level decode: classify the instruction, then look up its row.
    task automatic ref_decode(input logic [31:0] ins, output logic [5:0] c,
                              output logic [3:0] a, output logic [4:0] w, output logic ill);
        int op = ins[31:26];
        int fn = ins[5:0];
        c = 6'b000000; a = 4'b0000; w = 5'd0; ill = 1'b0;
        if (op == 0) begin
            if      (fn == 32) begin c = 6'b100000; a = 4'd2; w = ins[15:11]; end
            else if (fn == 34) begin c = 6'b100000; a = 4'd6; w = ins[15:11]; end
            else if (fn == 36) begin c = 6'b100000; a = 4'd0; w = ins[15:11]; end
            else if (fn == 37) begin c = 6'b100000; a = 4'd1; w = ins[15:11]; end
            else if (fn == 42) begin c = 6'b100000; a = 4'd7; w = ins[15:11]; end
            else ill = 1'b1;
        end
        else if (op == 35) begin c = 6'b110110; a = 4'd2; w = ins[20:16]; end
        else if (op == 43) begin c = 6'b001010; a = 4'd2; end
        else if (op == 4)  begin c = 6'b000001; a = 4'd6; end
        else if (op == 8)  begin c = 6'b100010; a = 4'd2; w = ins[20:16]; end
        else ill = 1'b1;
    endtask

    function automatic logic [31:0] ref_read(input logic [4:0] addr);
        if (addr == 0) return 32'd0;
        if (BYPASS && wb_en && wb_addr == addr) return wb_data;
        return model_regs[addr];
    endfunction

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    vec_t vecs [11];

    initial begin
        reset = 1'b1; instruction = 32'd0; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        #2;

        // Reset then add $3,$1,$2
        step();
        reset = 1'b0;
        instruction = 32'h00221820;
        settle();
        chk("reset_rd1", read_data1, 32'd0);
        chk("reset_rd2", read_data2, 32'd0);
        chk("reset_illegal", {31'd0, illegal_instr}, 32'd0);
        chk("add_reg_write", {31'd0, reg_write}, 32'd1);
        chk("add_write_reg", {27'd0, write_reg}, 32'd3);
        chk("add_alu_ctrl", {28'd0, alu_ctrl}, 32'h2);

        // Write then read via lw $4,16($5)
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        step();
        wb_en = 1'b0;
        instruction = 32'h8CA40010;
        settle();
        chk("lw_rd1", read_data1, 32'hDEADBEEF);
        chk("lw_rd2", read_data2, 32'd0);
        chk("lw_imm", imm_ext, 32'h00000010);
        chk("lw_ctrl", {26'd0, got_ctrl()}, {26'd0, 6'b110110});
        chk("lw_write_reg", {27'd0, write_reg}, 32'd4);

        // R0 stays zero
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
        step();
        wb_en = 1'b0;
        instruction = 32'h00002020;
        settle();
        chk("r0_read", read_data1, 32'd0);

        // beq with negative offset
        instruction = 32'h1022FFFC;
        settle();
        chk("beq_imm", imm_ext, 32'hFFFFFFFC);
        chk("beq_branch", {31'd0, branch}, 32'd1);
        chk("beq_alu", {28'd0, alu_ctrl}, 32'h6);
        chk("beq_reg_write", {31'd0, reg_write}, 32'd0);

        // Sticky illegal flag
        instruction = 32'hFC000000;
        settle();
        chk("illegal_ctrl", {26'd0, got_ctrl()}, 32'd0);
        chk("illegal_alu", {28'd0, alu_ctrl}, 32'd0);
        chk("illegal_wreg", {27'd0, write_reg}, 32'd0);
        chk("illegal_before_edge", {31'd0, illegal_instr}, 32'd0);
        step();
        instruction = 32'h00221820;
        settle();
        chk("illegal_set", {31'd0, illegal_instr}, 32'd1);
        step();
        step();
        chk("illegal_sticky", {31'd0, illegal_instr}, 32'd1);
        reset = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h55AA55AA;
        step();
        reset = 1'b0; wb_en = 1'b0;
        instruction = 32'h00E53020;
        settle();
        chk("illegal_cleared", {31'd0, illegal_instr}, 32'd0);
        chk("reset_clears_r5", read_data2, 32'd0);
        chk("reset_drops_wb", read_data1, 32'd0);

        // Decode vector table
        vecs[0]  = '{32'h00221820, 6'b100000, 4'b0010, 5'd3, 32'h00001820};
        vecs[1]  = '{32'h00221822, 6'b100000, 4'b0110, 5'd3, 32'h00001822};
        vecs[2]  = '{32'h00221824, 6'b100000, 4'b0000, 5'd3, 32'h00001824};
        vecs[3]  = '{32'h00221825, 6'b100000, 4'b0001, 5'd3, 32'h00001825};
        vecs[4]  = '{32'h0022182A, 6'b100000, 4'b0111, 5'd3, 32'h0000182A};
        vecs[5]  = '{32'h8CA40010, 6'b110110, 4'b0010, 5'd4, 32'h00000010};
        vecs[6]  = '{32'hACA40010, 6'b001010, 4'b0010, 5'd0, 32'h00000010};
        vecs[7]  = '{32'h1022FFFC, 6'b000001, 4'b0110, 5'd0, 32'hFFFFFFFC};
        vecs[8]  = '{32'h2023FF80, 6'b100010, 4'b0010, 5'd3, 32'hFFFFFF80};
        vecs[9]  = '{32'hFC000000, 6'b000000, 4'b0000, 5'd0, 32'h00000000};
        vecs[10] = '{32'h00221821, 6'b000000, 4'b0000, 5'd0, 32'h00001821};
        for (int i = 0; i < 11; i++) begin
            instruction = vecs[i].instr;
            settle();
            chk($sformatf("vec%0d_ctrl", i), {26'd0, got_ctrl()}, {26'd0, vecs[i].ctrl});
            chk($sformatf("vec%0d_alu", i), {28'd0, alu_ctrl}, {28'd0, vecs[i].alu});
            chk($sformatf("vec%0d_wreg", i), {27'd0, write_reg}, {27'd0, vecs[i].wreg});
            chk($sformatf("vec%0d_imm", i), imm_ext, vecs[i].imm);
        end

        // Bypass behaviour
        reset = 1'b1;
        step();
        reset = 1'b0;
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h0000AAAA;
        step();
        instruction = 32'h00221820;
        wb_data = 32'h00001234;
        settle();
        chk("bypass_same_cycle", read_data1, BYPASS ? 32'h00001234 : 32'h0000AAAA);
        step();
        wb_en = 1'b0;
        settle();
        chk("bypass_after_edge", read_data1, 32'h00001234);

        // Randomized run against the reference model
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int r = 0; r < 32; r++) model_regs[r] = 32'd0;
        model_ill = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            logic [5:0]  ec;
            logic [3:0]  ea;
            logic [4:0]  ew;
            logic        eill;
            int          kind;
            ins  = $urandom();
            kind = $urandom_range(0, 7);
            case (kind)
                0: begin
                    ins[31:26] = 6'h00;
                    case ($urandom_range(0, 4))
                        0: ins[5:0] = 6'h20;
                        1: ins[5:0] = 6'h22;
                        2: ins[5:0] = 6'h24;
                        3: ins[5:0] = 6'h25;
                        default: ins[5:0] = 6'h2A;
                    endcase
                end
                1: ins[31:26] = 6'h23;
                2: ins[31:26] = 6'h2B;
                3: ins[31:26] = 6'h04;
                4: ins[31:26] = 6'h08;
                5: ins[31:26] = 6'h00;
                default: ;
            endcase
            instruction = ins;
            reset   = ($urandom_range(0, 49) == 0);
            wb_en   = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0: wb_addr = ins[25:21];
                1: wb_addr = ins[20:16];
                2: wb_addr = 5'd0;
                default: wb_addr = 5'($urandom_range(0, 31));
            endcase
            wb_data = $urandom();
            settle();
            ref_decode(ins, ec, ea, ew, eill);
            chk("rnd_ctrl", {26'd0, got_ctrl()}, {26'd0, ec});
            chk("rnd_alu", {28'd0, alu_ctrl}, {28'd0, ea});
            chk("rnd_wreg", {27'd0, write_reg}, {27'd0, ew});
            chk("rnd_imm", imm_ext, {{16{ins[15]}}, ins[15:0]});
            chk("rnd_rd1", read_data1, ref_read(ins[25:21]));
            chk("rnd_rd2", read_data2, ref_read(ins[20:16]));
            chk("rnd_illegal", {31'd0, illegal_instr}, {31'd0, model_ill});
            step();
            if (reset) begin
                for (int r = 0; r < 32; r++) model_regs[r] = 32'd0;
                model_ill = 1'b0;
            end else begin
                if (wb_en && wb_addr != 0) model_regs[wb_addr] = wb_data;
                if (eill) model_ill = 1'b1;
            end
        end
        reset = 1'b0; wb_en = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath and register width.
REQ-002 SHALL have parameter REG_COUNT, default 32, number of architectural registers, addressed by 5 bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port instruction, input, 32, instruction word from the fetch stage.
REQ-006 SHALL have ports wb_en, input, 1; wb_addr, input, 5; wb_data, input, DATA_W: the write-back request.
REQ-007 SHALL have ports read_data1 and read_data2, output, DATA_W: rs and rt operands.
REQ-008 SHALL have ports imm_ext, output, 32, sign-extended instruction[15:0]; and write_reg, output, 5, destination register.
REQ-009 SHALL have control outputs, each 1 bit: reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch.
REQ-010 SHALL have ports alu_ctrl, output, 4, ALU operation; and illegal_instr, output, 1, sticky flag for an undecodable instruction.

Function
REQ-011 SHALL decode combinationally from instruction: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0].
REQ-012 SHALL support R-type (opcode 0x00) with funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt, mapped to alu_ctrl 0010, 0110, 0000, 0001, 0111 respectively.
REQ-013 SHALL support lw 0x23, sw 0x2B, beq 0x04 and addi 0x08; lw, sw and addi use alu_ctrl 0010; beq uses alu_ctrl 0110.
REQ-014 SHALL drive the following controls:
- R-type: reg_write=1, write_reg=rd.
- lw: reg_write, mem_read, mem_to_reg and alu_src =1; write_reg=rt.
- sw: mem_write and alu_src =1.
- beq: branch=1.
- addi: reg_write and alu_src =1; write_reg=rt.
- Every control not listed for an opcode is 0.
REQ-015 SHALL treat any other opcode, or an unsupported funct with opcode 0x00, as illegal: all controls 0, alu_ctrl 0000, write_reg 0.
REQ-016 SHALL set illegal_instr on the rising edge after an illegal instruction is presented; it holds at 1 until reset.
REQ-017 SHALL read the register file asynchronously: read_data1=R[rs], read_data2=R[rt], zero-latency.
REQ-018 SHALL write wb_data into R[wb_addr] on the rising edge when wb_en=1 and wb_addr!=0; data is visible on reads after that edge.
REQ-019 SHALL keep R0 permanently 0: writes to address 0 are ignored and reads of address 0 return 0.
REQ-020 SHALL compute imm_ext = {16{instruction[15]}, instruction[15:0]} for every opcode.
REQ-021 SHALL give reset priority over a simultaneous wb_en write.

Reset
REQ-022 SHALL, on a rising edge with reset=1, clear all REG_COUNT registers to 0 and clear illegal_instr to 0.
REQ-023 SHALL leave combinational outputs reflecting the current instruction during reset; read_data1/2 read 0 in the cycle after reset.
REQ-024 SHALL discard a write-back that coincides with a mid-operation reset.

Configuration
REQ-025 SHALL use macro WB_BYPASS_EN.
- Defined: when wb_en=1, wb_addr!=0 and wb_addr equals rs (or rt), read_data1 (or read_data2) SHALL return wb_data in the same cycle.
- Undefined: reads return the stored value until the write edge.

Structure
REQ-026 SHALL place opcode/funct localparams, alu_ctrl encodings and the register-address width in shared package cpu_pkg.
REQ-027 SHALL implement storage as sub-module register_file (2 async read ports, 1 sync write port, R0 hardwired, sync reset); decode logic stays in instruction_decode.

Verification
REQ-028 SHALL cover reset: assert reset 1 cycle, then instruction=0x00221820 (add $3,$1,$2) -> read_data1=read_data2=0, reg_write=1, write_reg=3, alu_ctrl=0010.
REQ-029 SHALL cover write-then-read: wb_en=1, wb_addr=5, wb_data=0xDEADBEEF for 1 edge, then instruction=0x8CA40010 (lw $4,16($5)) -> read_data1=0xDEADBEEF, imm_ext=0x00000010, mem_read=1, mem_to_reg=1, alu_src=1, write_reg=4.
REQ-030 SHALL cover R0: wb_en=1, wb_addr=0, wb_data=0xFFFFFFFF, then read rs=0 -> read_data1=0.
REQ-031 SHALL cover sign extension and beq: instruction=0x1022FFFC -> imm_ext=0xFFFFFFFC, branch=1, alu_ctrl=0110, reg_write=0.
REQ-032 SHALL cover the sticky illegal flag: instruction=0xFC000000 for 1 cycle, then a legal add -> illegal_instr=1 persists; then reset -> 0.
REQ-033 SHALL cover bypass: wb_en=1, wb_addr=1, wb_data=0x1234 while rs=1 -> read_data1=0x1234 same cycle with WB_BYPASS_EN defined; read_data1 = old value without it.
